// File: rtl/mk_design_pipe.sv
// Pipelined add/subtract unit with a credit-managed in-order result queue.
// Optional saturation on carry/borrow is enabled by defining DESIGN_PIPE_SAT_EN.
module mk_design_pipe #(
  parameter int unsigned WIDTH = 10,
  parameter int unsigned DEPTH = 4,
  parameter int unsigned LAT   = 2,
  parameter int unsigned MODE  = 0
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic [WIDTH-1:0] start_a,
  input  logic [WIDTH-1:0] start_b,
  input  logic             EN_start,
  output logic             RDY_start,
  output logic [WIDTH-1:0] res_result,
  output logic             RDY_result,
  input  logic             EN_check,
  output logic [WIDTH-1:0] ch_result,
  output logic             RDY_check
);

  localparam int unsigned CW = $clog2(DEPTH + 1);
  localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
`ifdef DESIGN_PIPE_SAT_EN
  localparam int unsigned DW = WIDTH + 1;
`else
  localparam int unsigned DW = WIDTH;
`endif

  logic [LAT-1:0]   pv_q;
  logic [DW-1:0]    pd_q [LAT];
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]    wr_q, rd_q;
  logic [CW-1:0]    count_q, inflight_q;
  logic [CW:0]      occ;
  logic [DW-1:0]    raw;
  logic             accept, pop, wr_en;

  // With saturation the top bit of each stage carries the carry/borrow out.
  always_comb begin
`ifdef DESIGN_PIPE_SAT_EN
    if (MODE == 0) raw = {1'b0, start_a} + {1'b0, start_b};
    else           raw = {1'b0, start_a} - {1'b0, start_b};
`else
    if (MODE == 0) raw = start_a + start_b;
    else           raw = start_a - start_b;
`endif
  end

  function automatic logic [WIDTH-1:0] clamp(input logic [DW-1:0] x);
`ifdef DESIGN_PIPE_SAT_EN
    if (x[WIDTH]) return (MODE == 0) ? {WIDTH{1'b1}} : {WIDTH{1'b0}};
    return x[WIDTH-1:0];
`else
    return x;
`endif
  endfunction

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  assign occ        = {1'b0, inflight_q} + {1'b0, count_q};
  assign RDY_start  = occ < (CW + 1)'(DEPTH);
  assign RDY_result = count_q != '0;
  assign RDY_check  = RDY_result;
  assign res_result = RDY_result ? mem_q[rd_q] : '0;
  assign ch_result  = res_result;

  assign accept = EN_start & RDY_start;
  assign pop    = EN_check & RDY_check;
  assign wr_en  = pv_q[LAT-1];

  always_ff @(posedge CLK) begin
    if (RST) begin
      pv_q       <= '0;
      for (int i = 0; i < LAT; i++) pd_q[i] <= '0;
      wr_q       <= '0;
      rd_q       <= '0;
      count_q    <= '0;
      inflight_q <= '0;
    end else begin
      pv_q[0] <= accept;
      pd_q[0] <= raw;
      for (int i = 1; i < LAT; i++) begin
        pv_q[i] <= pv_q[i-1];
        pd_q[i] <= pd_q[i-1];
      end
      // Clamp sits on the last stage output, so latency is unaffected.
      if (wr_en) begin
        mem_q[wr_q] <= clamp(pd_q[LAT-1]);
        wr_q        <= ptr_inc(wr_q);
      end
      if (pop) rd_q <= ptr_inc(rd_q);
      count_q    <= count_q + CW'(wr_en) - CW'(pop);
      inflight_q <= inflight_q + CW'(accept) - CW'(wr_en);
    end
  end

endmodule

// File: tb/tb_mk_design_pipe.sv
// Directed self-checking bench for mk_design_pipe (MODE 0 and MODE 1 instances).
module tb_mk_design_pipe;

  logic       CLK = 1'b0;
  logic       RST = 1'b1;
  logic [9:0] a0 = '0, b0 = '0, res0, ch0;
  logic       en_s0 = 1'b0, en_c0 = 1'b0, rdy_s0, rdy_r0, rdy_c0;
  logic [9:0] a1 = '0, b1 = '0, res1, ch1;
  logic       en_s1 = 1'b0, en_c1 = 1'b0, rdy_s1, rdy_r1, rdy_c1;

  int checks = 0;
  int failures = 0;

  always #5 CLK = ~CLK;

  mk_design_pipe #(.WIDTH(10), .DEPTH(4), .LAT(2), .MODE(0)) u_add (
    .CLK(CLK), .RST(RST), .start_a(a0), .start_b(b0), .EN_start(en_s0),
    .RDY_start(rdy_s0), .res_result(res0), .RDY_result(rdy_r0), .EN_check(en_c0),
    .ch_result(ch0), .RDY_check(rdy_c0)
  );

  mk_design_pipe #(.WIDTH(10), .DEPTH(4), .LAT(2), .MODE(1)) u_sub (
    .CLK(CLK), .RST(RST), .start_a(a1), .start_b(b1), .EN_start(en_s1),
    .RDY_start(rdy_s1), .res_result(res1), .RDY_result(rdy_r1), .EN_check(en_c1),
    .ch_result(ch1), .RDY_check(rdy_c1)
  );

  task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  logic [9:0] va [10] = '{100, 500, 0, 1, 256, 7, 300, 999, 12, 600};
  logic [9:0] vb [10] = '{23, 500, 0, 1022, 256, 8, 1, 24, 34, 400};
  logic [9:0] ve [10] = '{123, 1000, 0, 1023, 512, 15, 301, 1023, 46, 1000};

  initial begin
    int issued, popped, cyc;

    // Reset and idle
    tick(); tick();
    RST = 1'b0;
    tick();
    chk_eq("rst_rdy_start", rdy_s0, 1);
    chk_eq("rst_rdy_result", rdy_r0, 0);
    chk_eq("rst_rdy_check", rdy_c0, 0);
    chk_eq("rst_res", res0, 0);
    chk_eq("rst_ch", ch0, 0);
    chk_eq("rst_sub_rdy_start", rdy_s1, 1);

    // Single op latency: start in cycle 0, visible in cycle 3
    a0 = 3; b0 = 5; en_s0 = 1'b1;
    tick();
    en_s0 = 1'b0;
    chk_eq("lat_c1_rdy", rdy_r0, 0);
    tick();
    chk_eq("lat_c2_rdy", rdy_r0, 0);
    tick();
    chk_eq("lat_c3_rdy", rdy_r0, 1);
    chk_eq("lat_c3_res", res0, 8);
    chk_eq("lat_c3_ch", ch0, 8);
    en_c0 = 1'b1;
    tick();
    en_c0 = 1'b0;
    chk_eq("lat_c4_rdy", rdy_r0, 0);
    chk_eq("lat_c4_rdy_start", rdy_s0, 1);

    // Fill credits, fifth start ignored, in-order pops
    for (int i = 1; i <= 4; i++) begin
      chk_eq($sformatf("fill_rdy_start_%0d", i), rdy_s0, 1);
      a0 = 10'(i); b0 = 10'(i); en_s0 = 1'b1;
      tick();
    end
    chk_eq("fill_no_credit", rdy_s0, 0);
    a0 = 9; b0 = 9;
    tick();
    en_s0 = 1'b0;
    tick(); tick();
    chk_eq("fill_full_rdy_start", rdy_s0, 0);
    for (int i = 1; i <= 4; i++) begin
      chk_eq($sformatf("fill_pop_rdy_%0d", i), rdy_c0, 1);
      chk_eq($sformatf("fill_pop_val_%0d", i), ch0, 32'(2 * i));
      en_c0 = 1'b1;
      tick();
    end
    en_c0 = 1'b0;
    tick(); tick(); tick();
    chk_eq("fill_fifth_ignored", rdy_r0, 0);
    chk_eq("fill_credit_back", rdy_s0, 1);

    // Carry / borrow boundaries on both instances
    a0 = 1023; b0 = 2; en_s0 = 1'b1;
    a1 = 2; b1 = 5; en_s1 = 1'b1;
    tick();
    a0 = 512; b0 = 511;
    a1 = 5; b1 = 5;
    tick();
    en_s0 = 1'b0; en_s1 = 1'b0;
    tick();
`ifdef DESIGN_PIPE_SAT_EN
    chk_eq("sat_add_carry", res0, 1023);
    chk_eq("sat_sub_borrow", res1, 0);
`else
    chk_eq("wrap_add_carry", res0, 1);
    chk_eq("wrap_sub_borrow", res1, 1021);
`endif
    en_c0 = 1'b1; en_c1 = 1'b1;
    tick();
    chk_eq("add_no_carry", res0, 1023);
    chk_eq("sub_equal", res1, 0);
    chk_eq("sub_equal_rdy", rdy_r1, 1);
    tick();
    en_c0 = 1'b0; en_c1 = 1'b0;
    chk_eq("sub_drained", rdy_r1, 0);

    // Full queue with pop and start in the same cycle
    for (int i = 1; i <= 4; i++) begin
      a0 = 10'(10 * i); b0 = 0; en_s0 = 1'b1;
      tick();
    end
    en_s0 = 1'b0;
    tick(); tick();
    chk_eq("full_rdy_start", rdy_s0, 0);
    chk_eq("full_rdy_result", rdy_r0, 1);
    chk_eq("full_head", ch0, 10);
    a0 = 100; b0 = 0; en_s0 = 1'b1; en_c0 = 1'b1;
    tick();
    en_s0 = 1'b0; en_c0 = 1'b0;
    chk_eq("full_credit_next", rdy_s0, 1);
    for (int i = 2; i <= 4; i++) begin
      chk_eq($sformatf("full_pop_%0d", i), ch0, 32'(10 * i));
      en_c0 = 1'b1;
      tick();
    end
    en_c0 = 1'b0;
    tick(); tick(); tick();
    chk_eq("full_start_ignored", rdy_r0, 0);

    // Streaming ops with concurrent pops; pointers wrap repeatedly
    issued = 0; popped = 0; cyc = 0;
    while (popped < 10 && cyc < 100) begin
      if (rdy_c0) begin
        chk_eq($sformatf("stream_%0d", popped), ch0, 32'(ve[popped]));
        en_c0 = 1'b1;
        popped++;
      end else begin
        en_c0 = 1'b0;
      end
      if (issued < 10 && rdy_s0) begin
        a0 = va[issued]; b0 = vb[issued]; en_s0 = 1'b1;
        issued++;
      end else begin
        en_s0 = 1'b0;
      end
      tick();
      cyc++;
    end
    en_c0 = 1'b0; en_s0 = 1'b0;
    chk_eq("stream_done", popped, 10);
    chk_eq("stream_empty", rdy_r0, 0);

    // Reset with 2 queued and 2 in flight
    for (int i = 1; i <= 4; i++) begin
      a0 = 10'(i); b0 = 10'(i); en_s0 = 1'b1;
      tick();
    end
    en_s0 = 1'b0;
    chk_eq("pre_rst_queued", rdy_r0, 1);
    chk_eq("pre_rst_head", res0, 2);
    RST = 1'b1;
    tick();
    RST = 1'b0;
    chk_eq("mid_rst_rdy_result", rdy_r0, 0);
    chk_eq("mid_rst_rdy_start", rdy_s0, 1);
    chk_eq("mid_rst_res", res0, 0);
    for (int i = 0; i < 5; i++) begin
      tick();
      chk_eq($sformatf("post_rst_rdy_%0d", i), rdy_r0, 0);
      chk_eq($sformatf("post_rst_res_%0d", i), res0, 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
